dram_line_xfer: RTL and testbench
=================================

// Module: dram_line_xfer
// PURPOSE
//  Initiator side of the synchronous-read data RAM. Moves whole cache lines of LINE_WORDS words.
//  Line fill: reads the line out of the RAM. Line writeback: writes it in.
//  Sits between the cache controller (valid/ready request, one-cycle response pulse) and the RAM port (addr/din/we/dout).
//  Accounts for the RAM's one-cycle read latency: address is latched at the edge, dout is valid in the following cycle.
// PARAMETERS
//  AWIDTH      3   RAM address width; RAM depth = 1<<AWIDTH words
//  DWIDTH      32  word width
//  LINE_WORDS  2   words per line; power of 2, >=2, <= 1<<AWIDTH; OFFW = log2(LINE_WORDS)
// PORTS
//  clock      in   1                  single clock, all logic on posedge
//  reset_n    in   1                  synchronous, active-low reset
//  req_valid  in   1                  request present
//  req_ready  out  1                  high only in IDLE; request accepted at edge where req_valid&&req_ready
//  req_write  in   1                  1 = writeback, 0 = fill
//  req_line   in   AWIDTH-OFFW        line index; word address = {line, offset}
//  wb_data    in   DWIDTH*LINE_WORDS  writeback line, word 0 in LSBs; sampled at acceptance only
//  resp_valid out  1                  one-cycle completion pulse (fill and writeback)
//  resp_data  out  DWIDTH*LINE_WORDS  last filled line, word 0 in LSBs; stable until next fill completes
//  busy       out  1                  high in any state other than IDLE
//  mem_addr   out  AWIDTH             RAM address
//  mem_din    out  DWIDTH             RAM write data
//  mem_we     out  1                  RAM write enable
//  mem_dout   in   DWIDTH             RAM read data; valid the cycle after mem_addr is presented
// BEHAVIOUR
//  Reset (reset_n low at edge):
//   - state=IDLE; counters=0
//   - mem_addr=0, mem_din=0, mem_we=0
//   - resp_valid=0, resp_data=0, busy=0; req_ready=1 from the first cycle after reset
//  All outputs decode from registers only; no input-to-output combinational path.
//  States: IDLE -> WRITE | READ -> DONE -> IDLE.
//  IDLE: on acceptance, latch req_line, req_write, wb_data; offset counter=0; go WRITE if req_write, else READ.
//  WRITE: cycles k=1..N after acceptance (N=LINE_WORDS)
//   - mem_we=1, mem_addr={line,k-1}, mem_din=wb word k-1
//   - after k=N go DONE
//  READ: cycles k=1..N+1
//   - for k<=N: mem_addr={line,k-1}, mem_we=0
//   - at k=N+1: mem_addr holds {line,N-1}
//   - mem_dout captured at end of cycles 2..N+1 into word k-2 of fill buffer
//   - after k=N+1 go DONE
//  DONE: resp_valid=1 for exactly one cycle, then IDLE.
//   - fill: resp_data updated at the DONE-entry edge
//   - writeback: resp_data unchanged
//  Latency: writeback resp_valid in cycle N+1 after acceptance; fill in cycle N+2.
//   - Next request accepted no earlier than first cycle after DONE.
//  Addressing: offset counter is OFFW bits and never carries into the line bits; top line ends at 1<<AWIDTH-1, no wrap.
//  req_valid and inputs are ignored while busy; changes to req_line/wb_data mid-transfer have no effect.
//  mem_we=0 in every state except WRITE. mem_addr/mem_din hold their last value in IDLE/DONE.
//  Reset mid-transfer: abort at that edge; no further mem_we and no resp_valid.
//   - Words already written stay in RAM.
//   - resp_data keeps prior value only if reset is not applied; reset forces 0.
// TESTING (AWIDTH=3, DWIDTH=32, LINE_WORDS=2, bench RAM model with 1-cycle registered read address)
//  1 reset_n low 2 cycles -> req_ready=1, busy=0, mem_we=0, resp_valid=0, resp_data=0
//  2 write line 1, wb_data={32'hBBBB0002,32'hAAAA0001}
//    -> cycle1: we=1 addr=2 din=AAAA0001
//    -> cycle2: we=1 addr=3 din=BBBB0002
//    -> cycle3: resp_valid=1, resp_data unchanged
//  3 fill line 1 after test 2 -> addr 2,3 in cycles 1,2; resp_valid cycle 4; resp_data={BBBB0002,AAAA0001}, we never high
//  4 req_valid held high, fill line 3 then write line 0
//    -> addr 6,7 only (no access to 0 during fill)
//    -> second request accepted in cycle after DONE
//    -> resp_valid pulses are exactly 1 cycle each
//  5 while busy on fill of line 2, toggle req_line=0 and req_write=1 -> ignored; addr 4,5 only, no mem_we
//  6 write line 2 with reset_n low in cycle 1 -> word 4 written, word 5 keeps old value
//    -> mem_we=0 from next cycle; no resp_valid
//    -> then a fill of line 2 returns {old5, new4}

Source files
------------

// File: rtl/dram_line_xfer.sv
// dram_line_xfer: moves whole cache lines between the cache controller and a synchronous-read RAM.
module dram_line_xfer #(
  parameter int AWIDTH     = 3,
  parameter int DWIDTH     = 32,
  parameter int LINE_WORDS = 2
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_write_i,
  input  logic [AWIDTH-$clog2(LINE_WORDS)-1:0] req_line_i,
  input  logic [DWIDTH*LINE_WORDS-1:0] wb_data_i,
  output logic                         resp_valid_o,
  output logic [DWIDTH*LINE_WORDS-1:0] resp_data_o,
  output logic                         busy_o,
  output logic [AWIDTH-1:0]            mem_addr_o,
  output logic [DWIDTH-1:0]            mem_din_o,
  output logic                         mem_we_o,
  input  logic [DWIDTH-1:0]            mem_dout_i
);
  localparam int OFFW = $clog2(LINE_WORDS);
  localparam int LW   = AWIDTH - OFFW;
  localparam int LD   = DWIDTH * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t            state_q, state_d;
  logic [OFFW:0]     k_q, k_d;
  logic [LW-1:0]     line_q, line_d;
  logic [LD-1:0]     wb_q, wb_d, fill_q, fill_d, resp_q, resp_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] din_q, din_d;
  logic              we_q, we_d, rv_q, rv_d;
  logic [OFFW-1:0]   nxt_off, rd_off;

  // k_q counts cycles spent in WRITE/READ, starting at 0 in the first cycle
  assign nxt_off = k_q[OFFW-1:0] + OFFW'(1);
  assign rd_off  = k_q[OFFW-1:0] - OFFW'(1);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    line_d  = line_q;
    wb_d    = wb_q;
    fill_d  = fill_q;
    resp_d  = resp_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
    rv_d    = 1'b0;
    case (state_q)
      IDLE: if (req_valid_i) begin
        line_d  = req_line_i;
        wb_d    = wb_data_i;
        k_d     = '0;
        addr_d  = {req_line_i, OFFW'(0)};
        state_d = req_write_i ? WRITE : READ;
        we_d    = req_write_i;
        din_d   = req_write_i ? wb_data_i[DWIDTH-1:0] : din_q;
      end
      WRITE: if (k_q == (OFFW+1)'(LINE_WORDS-1)) begin
        state_d = DONE;
        rv_d    = 1'b1;
      end else begin
        k_d    = k_q + (OFFW+1)'(1);
        we_d   = 1'b1;
        addr_d = {line_q, nxt_off};
        din_d  = wb_q[DWIDTH*int'(nxt_off) +: DWIDTH];
      end
      READ: begin
        // read data trails the address by one cycle
        if (k_q != '0) fill_d[DWIDTH*int'(rd_off) +: DWIDTH] = mem_dout_i;
        if (k_q == (OFFW+1)'(LINE_WORDS)) begin
          state_d = DONE;
          rv_d    = 1'b1;
          resp_d  = fill_d;
        end else begin
          k_d    = k_q + (OFFW+1)'(1);
          addr_d = (k_q < (OFFW+1)'(LINE_WORDS-1)) ? {line_q, nxt_off} : addr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      line_q  <= '0;
      wb_q    <= '0;
      fill_q  <= '0;
      resp_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      line_q  <= line_d;
      wb_q    <= wb_d;
      fill_q  <= fill_d;
      resp_q  <= resp_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      rv_q    <= rv_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign resp_valid_o = rv_q;
  assign resp_data_o  = resp_q;
  assign mem_addr_o   = addr_q;
  assign mem_din_o    = din_q;
  assign mem_we_o     = we_q;
endmodule

// File: tb/tb_dram_line_xfer.sv
// tb_dram_line_xfer: directed and randomized line transfers checked against a word-array model of the RAM.
module tb_dram_line_xfer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [1:0]  req_line = '0;
  logic [63:0] wb_data = '0;
  logic        req_ready, resp_valid, busy, mem_we;
  logic [63:0] resp_data;
  logic [2:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic [31:0] ram [8] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17};
  logic [31:0] ref_mem [8] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17};
  logic [63:0] exp_resp = '0;
  int total = 0, bad = 0, w;

  dram_line_xfer #(.AWIDTH(3), .DWIDTH(32), .LINE_WORDS(2)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_line_i(req_line), .wb_data_i(wb_data),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .busy_o(busy),
    .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_we_o(mem_we), .mem_dout_i(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer; during it the request inputs are scrambled to prove they are ignored
  task automatic xfer(input bit wr, input logic [1:0] line, input logic [63:0] data, input bit hold,
                      output int waited);
    int last, base;
    last = wr ? 3 : 4;
    base = int'(line) * 2;
    waited = 0;
    req_valid = 1'b1; req_write = wr; req_line = line; wb_data = data;
    while (!req_ready && waited < 20) begin step(); waited++; end
    chk("req_ready_before", req_ready, 1);
    step();
    for (int k = 1; k <= last; k++) begin
      req_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
      req_write = 1'($urandom);
      req_line  = 2'($urandom);
      wb_data   = {$urandom, $urandom};
      chk("busy", busy, 1);
      chk("ready_low", req_ready, 0);
      if (wr && k <= 2) begin
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, base + k - 1);
        chk("wr_din", mem_din, data[32*(k-1) +: 32]);
        ref_mem[base + k - 1] = data[32*(k-1) +: 32];
      end else begin
        chk("no_we", mem_we, 0);
        if (!wr && k <= 3) chk("rd_addr", mem_addr, base + ((k > 2) ? 1 : k - 1));
      end
      if (!wr && k == last) exp_resp = {ref_mem[base + 1], ref_mem[base]};
      chk("resp_valid", resp_valid, (k == last) ? 1 : 0);
      chk("resp_data", resp_data, exp_resp);
      step();
    end
    chk("ready_after", req_ready, 1);
    chk("pulse_end", resp_valid, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    step(); step();
    rst_n = 1'b1;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    xfer(1'b1, 2'd1, {32'hBBBB0002, 32'hAAAA0001}, 1'b0, w);
    xfer(1'b0, 2'd1, 64'h0, 1'b0, w);
    chk("fill_line1", resp_data, {32'hBBBB0002, 32'hAAAA0001});
    xfer(1'b0, 2'd3, 64'h0, 1'b1, w);
    xfer(1'b1, 2'd0, {32'h0000CC01, 32'h0000CC00}, 1'b1, w);
    chk("back_to_back_wait", w, 0);
    xfer(1'b0, 2'd2, 64'h0, 1'b0, w);
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 12; i++) begin
      xfer(1'($urandom), 2'($urandom), {$urandom, $urandom}, 1'($urandom), w);
      req_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) step();
    end
    // abort a writeback after its first word
    req_valid = 1'b1; req_write = 1'b1; req_line = 2'd2; wb_data = {32'hDEAD0005, 32'hCAFE0004};
    step();
    req_valid = 1'b0;
    chk("abort_we", mem_we, 1);
    chk("abort_addr", mem_addr, 4);
    rst_n = 1'b0;
    ref_mem[4] = 32'hCAFE0004;
    exp_resp = '0;
    step();
    rst_n = 1'b1;
    chk("abort_we_off", mem_we, 0);
    chk("abort_rv", resp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", resp_data, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_quiet_rv", resp_valid, 0);
      chk("abort_quiet_we", mem_we, 0);
    end
    xfer(1'b0, 2'd2, 64'h0, 1'b0, w);
    chk("abort_fill", resp_data, {ref_mem[5], 32'hCAFE0004});
    req_valid = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
